// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if
//   Groups the fetch stage's bus signals: the instruction-memory address and
//   data pair, the valid/ready slot towards execute, and the start/halted
//   control pair.
//
//   Handshake: instr_out/instr_valid are driven by the fetch stage. A word
//   transfers on any rising edge where instr_valid && instr_ready. While
//   instr_valid is high and instr_ready is low, instr_out and instr_valid
//   stay stable. instr_ready may depend on instr_valid, but the fetch stage
//   never derives instr_valid from instr_ready.
//
//   Modports:
//     master - the fetch stage (drives pc, instr_out, instr_valid, halted)
//     slave  - memory + execute + control side (drives instruction,
//              instr_ready, start)
interface instruction_fetch_if #(
  parameter int PC_WIDTH          = 4,
  parameter int INSTRUCTION_WIDTH = 12
);
  logic [PC_WIDTH-1:0]          pc;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic [INSTRUCTION_WIDTH-1:0] instr_out;
  logic                         instr_valid;
  logic                         instr_ready;
  logic                         start;
  logic                         halted;

  modport master (
    output pc, instr_out, instr_valid, halted,
    input  instruction, instr_ready, start
  );

  modport slave (
    input  pc, instr_out, instr_valid, halted,
    output instruction, instr_ready, start
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage of the PucCPU core. Owns the program counter, presents it to
//   the combinational instruction memory, and registers the returned word into
//   a valid/ready slot for execute. JUMP and RESET opcodes redirect pc on the
//   same edge that loads them. An all-zero word stops fetch until start.
//
// Ports:
//   clk         - clock, rising edge
//   reset_n     - asynchronous active-low reset
//   bus         - instruction_fetch_if.master (pc, instruction, instr_out,
//                 instr_valid, instr_ready, start, halted)
//   o_dbg_state - current FSM state (0 = RUN, 1 = HALT)
module instruction_fetch #(
  parameter int         PC_WIDTH          = 4,
  parameter int         INSTRUCTION_WIDTH = 12,
  parameter logic [3:0] JUMP              = 4'hE,
  parameter logic [3:0] RESET             = 4'hF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  instruction_fetch_if.master         bus,
  output logic                        o_dbg_state
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                       r_state;
  logic [PC_WIDTH-1:0]          r_pc;
  logic [INSTRUCTION_WIDTH-1:0] r_instr_out;
  logic                         r_instr_valid;
  logic                         r_halted;

  logic                         w_slot_free;
  logic                         w_xfer;
  logic                         w_zero_word;
  logic [3:0]                   w_opcode;

  assign w_slot_free = !r_instr_valid || bus.instr_ready;
  assign w_xfer      = r_instr_valid && bus.instr_ready;
  assign w_zero_word = (bus.instruction == '0);
  assign w_opcode    = bus.instruction[INSTRUCTION_WIDTH-1 -: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_pc          <= PC_WIDTH'(1);
      r_instr_out   <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_slot_free) begin
            if (!w_zero_word) begin
              r_instr_out   <= bus.instruction;
              r_instr_valid <= 1'b1;
              // Redirects take effect on the loading edge, so the target
              // word is fetched next cycle with no bubble.
              if (w_opcode == JUMP)
                r_pc <= bus.instruction[PC_WIDTH-1:0];
              else if (w_opcode == RESET)
                r_pc <= PC_WIDTH'(1);
              else
                r_pc <= r_pc + PC_WIDTH'(1);
            end else begin
              // Zero word ends the program; the previous word may still be
              // leaving on this same edge.
              if (w_xfer)
                r_instr_valid <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          if (w_xfer)
            r_instr_valid <= 1'b0;
          if (bus.start) begin
            r_pc     <= PC_WIDTH'(1);
            r_halted <= 1'b0;
            r_state  <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Directed bench for instruction_fetch. A bench-owned memory array answers
//   pc combinationally; the program is patched between phases so each phase
//   (straight line, jump, stall, RESET opcode, halt, wrap, async reset) runs
//   once. Inputs change and outputs are sampled on the falling edge.
module tb_instruction_fetch;
  localparam int PW = 4;
  localparam int IW = 12;

  logic clk;
  logic reset_n;
  logic dbg_state;
  logic [IW-1:0] mem [16];

  int n_checks;
  int n_errors;

  instruction_fetch_if #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW)) bus ();

  instruction_fetch #(
    .PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .JUMP(4'hE), .RESET(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master),
    .o_dbg_state(dbg_state)
  );

  assign bus.instruction = mem[bus.pc];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [PW-1:0] e_pc,
                         input logic [IW-1:0] e_out, input logic e_valid,
                         input logic e_halted);
    chk({tag, ".pc"},     32'(bus.pc),          32'(e_pc));
    chk({tag, ".out"},    32'(bus.instr_out),   32'(e_out));
    chk({tag, ".valid"},  32'(bus.instr_valid), 32'(e_valid));
    chk({tag, ".halted"}, 32'(bus.halted),      32'(e_halted));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[1] = 12'h103; // LOADI 3
    mem[2] = 12'h200; // MOVE
    mem[3] = 12'h101; // LOADI 1
    mem[4] = 12'h300; // ADD
    mem[5] = 12'hE14; // JUMP 0x14 -> address 4 (upper operand bits ignored)
    mem[6] = 12'h107;
    mem[7] = 12'h300;
    mem[8] = 12'hF00; // RESET
    mem[9] = 12'h000; // program end
    reset_n = 1'b0;
    bus.instr_ready = 1'b1;
    bus.start = 1'b0;

    step(); step();
    chk_out("reset", 4'd1, 12'h000, 1'b0, 1'b0);
    chk("reset.state", 32'(dbg_state), 32'd0);

    // Straight line: each word appears one cycle after its address.
    reset_n = 1'b1;
    step(); chk_out("sl1", 4'd2, 12'h103, 1'b1, 1'b0);
    step(); chk_out("sl2", 4'd3, 12'h200, 1'b1, 1'b0);
    step(); chk_out("sl3", 4'd4, 12'h101, 1'b1, 1'b0);
    step(); chk_out("sl4", 4'd5, 12'h300, 1'b1, 1'b0);

    // JUMP forwarded, redirect without bubble.
    step(); chk_out("jmp", 4'd4, 12'hE14, 1'b1, 1'b0);
    mem[5] = 12'h106;
    step(); chk_out("jmp_tgt", 4'd5, 12'h300, 1'b1, 1'b0);
    step(); chk_out("a5", 4'd6, 12'h106, 1'b1, 1'b0);

    // Back-pressure for three cycles.
    bus.instr_ready = 1'b0;
    step(); chk_out("stall1", 4'd6, 12'h106, 1'b1, 1'b0);
    step(); chk_out("stall2", 4'd6, 12'h106, 1'b1, 1'b0);
    step(); chk_out("stall3", 4'd6, 12'h106, 1'b1, 1'b0);
    bus.instr_ready = 1'b1;
    step(); chk_out("resume", 4'd7, 12'h107, 1'b1, 1'b0);
    step(); chk_out("a7", 4'd8, 12'h300, 1'b1, 1'b0);

    // RESET opcode forwarded, pc back to 1.
    step(); chk_out("rst_op", 4'd1, 12'hF00, 1'b1, 1'b0);
    mem[8] = 12'h108;
    step(); chk_out("rst_tgt", 4'd2, 12'h103, 1'b1, 1'b0);
    step(); step(); step(); step(); step(); step();
    chk_out("run7", 4'd8, 12'h300, 1'b1, 1'b0);
    step(); chk_out("a8", 4'd9, 12'h108, 1'b1, 1'b0);

    // Zero word with transfer on the same edge.
    step(); chk_out("halt", 4'd9, 12'h108, 1'b0, 1'b1);
    chk("halt.state", 32'(dbg_state), 32'd1);
    step(); chk_out("halt_hold", 4'd9, 12'h108, 1'b0, 1'b1);

    // Restart, then jump to 15 and wrap to address 0 (zero word).
    mem[1]  = 12'hE0F;
    mem[15] = 12'h1FF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("start", 4'd1, 12'h108, 1'b0, 1'b0);
    chk("start.state", 32'(dbg_state), 32'd0);
    step(); chk_out("jmp15", 4'd15, 12'hE0F, 1'b1, 1'b0);
    bus.start = 1'b1; // ignored in RUN
    step();
    bus.start = 1'b0;
    chk_out("wrap", 4'd0, 12'h1FF, 1'b1, 1'b0);
    step(); chk_out("halt0", 4'd0, 12'h1FF, 1'b0, 1'b1);

    // Restart, stall, then asynchronous reset between edges.
    mem[1] = 12'h103;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("start2", 4'd1, 12'h1FF, 1'b0, 1'b0);
    step(); chk_out("r2a1", 4'd2, 12'h103, 1'b1, 1'b0);
    bus.instr_ready = 1'b0;
    step(); chk_out("r2stall", 4'd2, 12'h103, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_out("async_rst", 4'd1, 12'h000, 1'b0, 1'b0);
    chk("async_rst.state", 32'(dbg_state), 32'd0);
    step();
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    step(); chk_out("post_rst", 4'd2, 12'h103, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
